// File: rtl/comb_str_seq_pkg.sv
// Shared types and constants for the comb_str sweep sequencer.
package comb_str_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam int         NUM_VEC  = 32;
  localparam logic [4:0] LAST_IDX = 5'd31;

endpackage

// File: rtl/comb_str_ref.sv
// Golden model of the comb_str datapath: sel-muxed NAND(A,B) / NAND(C,D).
module comb_str_ref (
  input  logic sel_i,
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  input  logic d_i,
  output logic y_o
);

  assign y_o = sel_i ? ~(c_i & d_i) : ~(a_i & b_i);

endmodule

// File: rtl/comb_str_seq.sv
// Sweep sequencer/BIST for comb_str: walks all 32 {sel,A,B,C,D} vectors and checks p_y.
// Define COMB_STR_SEQ_SELFCHECK_EN to build the compare logic and error capture.
module comb_str_seq
  import comb_str_seq_pkg::*;
#(
  parameter int SETTLE = 1,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          p_y,
  output logic          A,
  output logic          B,
  output logic          C,
  output logic          D,
  output logic          sel,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] err_cnt,
  output logic [4:0]    first_err_idx
);

  localparam logic [3:0] SETTLE_TC = 4'(SETTLE);

  state_e     state_q;
  logic [4:0] idx_q;
  logic [3:0] wcnt_q;
  logic       busy_q;
  logic       done_q;
  logic       launch;
  logic       sample_hit;

  assign launch     = (state_q == S_IDLE) && start && !abort;
  assign sample_hit = (state_q == S_RUN) && !abort && (wcnt_q == SETTLE_TC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wcnt_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (launch) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
            idx_q   <= '0;
            wcnt_q  <= '0;
          end
        end
        S_RUN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            wcnt_q  <= '0;
          end else if (sample_hit) begin
            wcnt_q <= '0;
            if (idx_q == LAST_IDX) begin
              state_q <= S_FIN;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q <= idx_q + 5'd1;
            end
          end else begin
            wcnt_q <= wcnt_q + 4'd1;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // The vector register is the sweep index itself, so it holds through IDLE.
  assign {sel, A, B, C, D} = idx_q;
  assign busy              = busy_q;
  assign done              = done_q;

`ifdef COMB_STR_SEQ_SELFCHECK_EN
  logic          exp_y;
  logic [CW-1:0] err_cnt_q, err_cnt_d;
  logic [4:0]    first_err_idx_q, first_err_idx_d;

  comb_str_ref u_ref (
    .sel_i (idx_q[4]),
    .a_i   (idx_q[3]),
    .b_i   (idx_q[2]),
    .c_i   (idx_q[1]),
    .d_i   (idx_q[0]),
    .y_o   (exp_y)
  );

  always_comb begin
    err_cnt_d       = err_cnt_q;
    first_err_idx_d = first_err_idx_q;
    if (launch) begin
      err_cnt_d       = '0;
      first_err_idx_d = '0;
    end else if (sample_hit && (p_y != exp_y)) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 1'b1;
      if (err_cnt_q == '0) first_err_idx_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt_q       <= '0;
      first_err_idx_q <= '0;
    end else begin
      err_cnt_q       <= err_cnt_d;
      first_err_idx_q <= first_err_idx_d;
    end
  end

  assign err_cnt       = err_cnt_q;
  assign first_err_idx = first_err_idx_q;
`else
  logic unused_p_y;
  assign unused_p_y    = p_y;
  assign err_cnt       = '0;
  assign first_err_idx = '0;
`endif

endmodule

// File: tb/tb_comb_str_seq.sv
// Self-checking bench for comb_str_seq: two instances (SETTLE=1 and SETTLE=3) with fault-injected p_y.
module tb_comb_str_seq;

`ifdef COMB_STR_SEQ_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        st     [2];
  logic        ab     [2];
  logic        py     [2];
  logic        a_o    [2];
  logic        b_o    [2];
  logic        c_o    [2];
  logic        d_o    [2];
  logic        sel_o  [2];
  logic        busy_o [2];
  logic        done_o [2];
  logic [7:0]  err_o  [2];
  logic [4:0]  fei_o  [2];
  logic [31:0] fmask  [2];
  logic [4:0]  vec    [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic golden(input logic [4:0] v);
    return v[4] ? ~(v[1] & v[0]) : ~(v[3] & v[2]);
  endfunction

  // p_y seen by each DUT: the true datapath output, flipped wherever the fault mask is set.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      vec[k] = {sel_o[k], a_o[k], b_o[k], c_o[k], d_o[k]};
      py[k]  = golden({sel_o[k], a_o[k], b_o[k], c_o[k], d_o[k]})
               ^ fmask[k][{sel_o[k], a_o[k], b_o[k], c_o[k], d_o[k]}];
    end
  end

  comb_str_seq #(.SETTLE(1), .CW(8)) u_dut0 (
    .clk(clk), .reset(rst[0]), .start(st[0]), .abort(ab[0]), .p_y(py[0]),
    .A(a_o[0]), .B(b_o[0]), .C(c_o[0]), .D(d_o[0]), .sel(sel_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err_cnt(err_o[0]), .first_err_idx(fei_o[0])
  );

  comb_str_seq #(.SETTLE(3), .CW(8)) u_dut1 (
    .clk(clk), .reset(rst[1]), .start(st[1]), .abort(ab[1]), .p_y(py[1]),
    .A(a_o[1]), .B(b_o[1]), .C(c_o[1]), .D(d_o[1]), .sel(sel_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err_cnt(err_o[1]), .first_err_idx(fei_o[1])
  );

  function automatic int settle_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] stuck0_mask();
    logic [31:0] m;
    for (int i = 0; i < 32; i++) m[i] = golden(5'(i));
    return m;
  endfunction

  function automatic logic [7:0] exp_err(input logic [31:0] m);
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m[i]);
    if (!SC) return 8'd0;
    return (c > 255) ? 8'd255 : 8'(c);
  endfunction

  function automatic logic [4:0] exp_fei(input logic [31:0] m);
    if (!SC) return 5'd0;
    for (int i = 0; i < 32; i++) if (m[i]) return 5'(i);
    return 5'd0;
  endfunction

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; st[k] = 1'b0; ab[k] = 1'b0; fmask[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({busy_o[k], done_o[k], vec[k]} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_ctl dut%0d: got %b required 0", k, {busy_o[k], done_o[k], vec[k]});
      end
      n_checks++;
      if ({err_o[k], fei_o[k]} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset_err dut%0d: got err=%0d idx=%0d required 0/0", k, err_o[k], fei_o[k]);
      end
    end
  endtask

  // Caller leaves the DUT idle at a negedge; returns idle at a negedge with vector 31.
  task automatic test_sweep(input int d, input logic [31:0] mask, input bit poke, input string tag);
    int s, len;
    logic [6:0] expv;
    s   = settle_of(d);
    len = 32 * (s + 1);
    fmask[d] = mask;
    st[d] = 1'b1; ab[d] = 1'b0;
    @(negedge clk);
    for (int n = 1; n <= len + 2; n++) begin
      if (n <= len)          expv = {1'b1, 1'b0, 5'((n - 1) / (s + 1))};
      else if (n == len + 1) expv = {1'b0, 1'b1, 5'd31};
      else                   expv = {1'b0, 1'b0, 5'd31};
      n_checks++;
      if ({busy_o[d], done_o[d], vec[d]} !== expv) begin
        n_fail++;
        $display("FAIL %s dut%0d cycle %0d: busy/done/vec got %b required %b",
                 tag, d, n, {busy_o[d], done_o[d], vec[d]}, expv);
      end
      st[d] = (poke && n <= len + 1) ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (n < len + 2) @(negedge clk);
    end
    n_checks++;
    if (err_o[d] !== exp_err(mask)) begin
      n_fail++;
      $display("FAIL %s_err dut%0d: got %0d required %0d", tag, d, err_o[d], exp_err(mask));
    end
    n_checks++;
    if (fei_o[d] !== exp_fei(mask)) begin
      n_fail++;
      $display("FAIL %s_first dut%0d: got %0d required %0d", tag, d, fei_o[d], exp_fei(mask));
    end
  endtask

  task automatic test_abort(input int d);
    int s, errs;
    logic [31:0] mask;
    logic [4:0]  held;
    s    = settle_of(d);
    mask = 32'h0000_0016;
    // Vectors fully sampled before the 10th RUN cycle; the abort cycle itself takes no sample.
    errs = 0;
    for (int n = 1; n <= 9; n++) if (n % (s + 1) == 0) errs += int'(mask[n / (s + 1) - 1]);
    held = 5'(9 / (s + 1));
    fmask[d] = mask;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    repeat (9) @(negedge clk);
    n_checks++;
    if ({busy_o[d], vec[d]} !== {1'b1, held}) begin
      n_fail++;
      $display("FAIL abort_pre dut%0d: busy/vec got %b required %b", d, {busy_o[d], vec[d]}, {1'b1, held});
    end
    ab[d] = 1'b1;
    @(negedge clk);
    ab[d] = 1'b0;
    for (int n = 0; n < 5; n++) begin
      n_checks++;
      if ({busy_o[d], done_o[d], vec[d]} !== {2'b00, held}) begin
        n_fail++;
        $display("FAIL abort_idle dut%0d +%0d: got %b required %b",
                 d, n, {busy_o[d], done_o[d], vec[d]}, {2'b00, held});
      end
      @(negedge clk);
    end
    n_checks++;
    if (err_o[d] !== (SC ? 8'(errs) : 8'd0)) begin
      n_fail++;
      $display("FAIL abort_err dut%0d: got %0d required %0d", d, err_o[d], SC ? errs : 0);
    end
    n_checks++;
    if (fei_o[d] !== (SC ? 5'd1 : 5'd0)) begin
      n_fail++;
      $display("FAIL abort_first dut%0d: got %0d required %0d", d, fei_o[d], SC ? 1 : 0);
    end
    test_sweep(d, 32'h0, 1'b0, "after_abort");
  endtask

  task automatic test_idle_start_abort(input int d);
    st[d] = 1'b1; ab[d] = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (n == 3) begin st[d] = 1'b0; ab[d] = 1'b0; end
      n_checks++;
      if ({busy_o[d], done_o[d], vec[d]} !== {2'b00, 5'd31}) begin
        n_fail++;
        $display("FAIL start_abort_idle dut%0d +%0d: got %b required %b",
                 d, n, {busy_o[d], done_o[d], vec[d]}, {2'b00, 5'd31});
      end
    end
  endtask

  task automatic test_reset_mid(input int d);
    bit found = 1'b0;
    fmask[d] = 32'h0000_0005;
    st[d] = 1'b1;
    @(negedge clk);
    st[d] = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (vec[d] == 5'd7) found = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL reset_mid_wait dut%0d: vector 7 not seen within 400 cycles, vec=%0d", d, vec[d]);
    end
    n_checks++;
    if (err_o[d] !== (SC ? 8'd2 : 8'd0)) begin
      n_fail++;
      $display("FAIL reset_mid_partial dut%0d: got %0d required %0d", d, err_o[d], SC ? 2 : 0);
    end
    rst[d] = 1'b1;
    @(negedge clk);
    rst[d] = 1'b0;
    n_checks++;
    if ({busy_o[d], done_o[d], vec[d], err_o[d], fei_o[d]} !== 20'd0) begin
      n_fail++;
      $display("FAIL reset_mid dut%0d: busy=%b done=%b vec=%0d err=%0d idx=%0d required all 0",
               d, busy_o[d], done_o[d], vec[d], err_o[d], fei_o[d]);
    end
    @(negedge clk);
    test_sweep(d, stuck0_mask(), 1'b0, "settle3_stuck0");
  endtask

  initial begin
    test_reset();
    test_sweep(0, 32'h0, 1'b0, "good");
    test_sweep(0, stuck0_mask(), 1'b0, "stuck0");
    test_abort(0);
    test_idle_start_abort(0);
    test_sweep(0, $urandom(), 1'b1, "poke_start");
    for (int r = 0; r < 3; r++) test_sweep(0, $urandom() & $urandom(), 1'b0, "back_to_back");
    test_reset_mid(1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
